// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronised, debounced buttons drive a 4-state FSM, a prescaled BCD counter and a lap display latch.
// Optional build macro STOPWATCH_SEXAGESIMAL_EN: digit 2 counts 0..5 (m:ss.t); otherwise every digit counts 0..9.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 10,
  parameter int DIGITS          = 4
) (
  input  logic                  Crystal,
  input  logic                  nSysReset,
  input  logic [1:2]            Buttons,
  output logic [4*DIGITS-1:0]   Digits,
  output logic                  WatchRunning,
  output logic                  WatchReset,
  output logic                  Lapped,
  output logic                  Overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_ZERO    = 2'd0,
    S_RUNNING = 2'd1,
    S_LAP     = 2'd2,
    S_STOPPED = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CW-1:0]         cnt_q [2];
  logic                  press1, press2;
  logic                  counting, tick, enter_zero, carry;
  logic [PW-1:0]         pre_q, pre_d;
  logic [4*DIGITS-1:0]   count_q, count_d, count_inc;
  logic [4*DIGITS-1:0]   lap_q, lap_d, digits_q, digits_d;
  logic [3:0]            dmax;
  logic                  ovf_q, ovf_d, wreset_q;

  assign btn_raw = {Buttons[2], Buttons[1]};

  // A new level is accepted only after DEBOUNCE_CYCLES+1 consecutive differing samples.
  always_ff @(posedge Crystal or negedge nSysReset) begin
    if (!nSysReset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] != deb_q[b]) begin
          if (cnt_q[b] == CW'(DEBOUNCE_CYCLES)) begin
            deb_q[b] <= sync2_q[b];
            cnt_q[b] <= '0;
          end else begin
            cnt_q[b] <= cnt_q[b] + 1'b1;
          end
        end else begin
          cnt_q[b] <= '0;
        end
      end
    end
  end

  assign press1 = deb_q[0] & ~deb_prev_q[0];
  assign press2 = deb_q[1] & ~deb_prev_q[1];

  always_ff @(posedge Crystal or negedge nSysReset) begin
    if (!nSysReset) state_q <= S_ZERO;
    else            state_q <= state_d;
  end

  // Start/stop always wins over lap/reset when both are pressed together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ZERO:    if (press1) state_d = S_RUNNING;
      S_RUNNING: if (press1) state_d = S_STOPPED; else if (press2) state_d = S_LAP;
      S_LAP:     if (press1) state_d = S_STOPPED; else if (press2) state_d = S_RUNNING;
      S_STOPPED: if (press1) state_d = S_RUNNING; else if (press2) state_d = S_ZERO;
      default:   state_d = S_ZERO;
    endcase
  end

  always_comb begin
    counting   = (state_q == S_RUNNING) || (state_q == S_LAP);
    enter_zero = (state_d == S_ZERO) && (state_q != S_ZERO);
    tick       = counting && (pre_q == PW'(TICK_DIV - 1));
  end

  always_comb begin
    pre_d = pre_q;
    if (enter_zero)  pre_d = '0;
    else if (tick)   pre_d = '0;
    else if (counting) pre_d = pre_q + 1'b1;
  end

  // Ripple BCD increment; a carry out of the top digit is the overflow wrap.
  always_comb begin
    count_inc = count_q;
    carry     = tick;
    dmax      = 4'd9;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef STOPWATCH_SEXAGESIMAL_EN
      dmax = (i == 2) ? 4'd5 : 4'd9;
`else
      dmax = 4'd9;
`endif
      if (carry) begin
        if (count_q[4*i +: 4] == dmax) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d  = enter_zero ? '0 : count_inc;
    ovf_d    = enter_zero ? 1'b0 : (ovf_q | carry);
    lap_d    = ((state_q == S_RUNNING) && (state_d == S_LAP)) ? count_q : lap_q;
    digits_d = (state_q == S_LAP) ? lap_q : count_q;
  end

  always_ff @(posedge Crystal or negedge nSysReset) begin
    if (!nSysReset) begin
      pre_q    <= '0;
      count_q  <= '0;
      lap_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      wreset_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      count_q  <= count_d;
      lap_q    <= lap_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      wreset_q <= enter_zero;
    end
  end

  always_comb begin
    WatchRunning = (state_q == S_RUNNING) || (state_q == S_LAP);
    Lapped       = (state_q == S_LAP);
    WatchReset   = wreset_q;
    Overflow     = ovf_q;
    Digits       = digits_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: press-level behavioural model checked every cycle, a vector table, and corner sequences.
module tb_stopwatch_ctrl;
  localparam int DEB  = 4;
  localparam int TDIV = 2;
  localparam int NDIG = 4;

  logic                Crystal = 1'b0;
  logic                nSysReset = 1'b0;
  logic [1:2]          Buttons = '0;
  logic [4*NDIG-1:0]   Digits;
  logic                WatchRunning, WatchReset, Lapped, Overflow;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV), .DIGITS(NDIG)) dut (
    .Crystal(Crystal), .nSysReset(nSysReset), .Buttons(Buttons), .Digits(Digits),
    .WatchRunning(WatchRunning), .WatchReset(WatchReset), .Lapped(Lapped), .Overflow(Overflow)
  );

  always #5 Crystal = ~Crystal;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: time is an integer number of counting cycles, displayed in mixed radix.
  typedef enum {M_ZERO, M_RUN, M_LAP, M_STOP} mode_t;
  mode_t      m;
  int         run_cyc, lap_val, exp_disp, nv, edge_n;
  bit         exp_wr, exp_ovf, chk_en;
  int         ev_e[$];
  logic [1:0] ev_b[$];

  function automatic int radix(input int i);
`ifdef STOPWATCH_SEXAGESIMAL_EN
    if (i == 2) return 6;
`endif
    return 10;
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input int n);
    logic [4*NDIG-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(n % radix(i));
      n = n / radix(i);
    end
    return r;
  endfunction

  task automatic model_reset();
    m = M_ZERO; run_cyc = 0; lap_val = 0; exp_disp = 0; exp_wr = 0; exp_ovf = 0;
    ev_e.delete(); ev_b.delete();
  endtask

  task automatic model_edge();
    bit p1, p2;
    int cur;
    p1 = 0; p2 = 0;
    if (!nSysReset) begin
      model_reset();
      return;
    end
    for (int i = ev_e.size() - 1; i >= 0; i--) begin
      if (ev_e[i] == edge_n) begin
        p1 |= ev_b[i][0];
        p2 |= ev_b[i][1];
        ev_e.delete(i);
        ev_b.delete(i);
      end
    end
    cur      = (run_cyc / TDIV) % nv;
    exp_disp = (m == M_LAP) ? lap_val : cur;
    exp_wr   = 0;
    if (m == M_RUN || m == M_LAP) begin
      run_cyc++;
      if (run_cyc / TDIV >= nv) exp_ovf = 1;
    end
    case (m)
      M_ZERO: if (p1) m = M_RUN;
      M_RUN:  if (p1) m = M_STOP; else if (p2) begin m = M_LAP; lap_val = cur; end
      M_LAP:  if (p1) m = M_STOP; else if (p2) m = M_RUN;
      M_STOP: if (p1) m = M_RUN;
              else if (p2) begin m = M_ZERO; run_cyc = 0; exp_ovf = 0; exp_wr = 1; end
      default: m = M_ZERO;
    endcase
  endtask

  task automatic cyc();
    @(posedge Crystal);
    edge_n++;
    model_edge();
    @(negedge Crystal);
    if (chk_en) begin
      chk("digits",  Digits, to_bcd(exp_disp));
      chk("running", WatchRunning, (m == M_RUN || m == M_LAP));
      chk("lapped",  Lapped, (m == M_LAP));
      chk("wreset",  WatchReset, exp_wr);
      chk("ovf",     Overflow, exp_ovf);
    end
  endtask

  // A held level of DEB+1 cycles or more becomes a press DEB+3 edges after the first sampling edge.
  task automatic schedule(input bit b1, input bit b2);
    ev_e.push_back(edge_n + 4 + DEB);
    ev_b.push_back({b2, b1});
  endtask

  task automatic press(input bit b1, input bit b2, input int hold, input int gap);
    Buttons[1] = b1;
    Buttons[2] = b2;
    if (hold >= DEB + 1) schedule(b1, b2);
    repeat (hold) cyc();
    Buttons = '0;
    repeat (gap) cyc();
  endtask

  typedef struct {
    bit b1; bit b2; int hold; bit run; bit lap; bit ovf;
  } vec_t;
  vec_t vt[16];

  logic [4*NDIG-1:0] max_bcd, mid_lo, mid_hi;
  int mid_lo_n;

  initial begin
    vt[0]  = '{0, 1, 8, 1, 1, 0};
    vt[1]  = '{0, 1, 8, 1, 0, 0};
    vt[2]  = '{1, 0, 8, 0, 0, 0};
    vt[3]  = '{1, 0, 3, 0, 0, 0};
    vt[4]  = '{1, 0, 8, 1, 0, 0};
    vt[5]  = '{0, 1, 8, 1, 1, 0};
    vt[6]  = '{1, 0, 8, 0, 0, 0};
    vt[7]  = '{0, 1, 8, 0, 0, 0};
    vt[8]  = '{0, 1, 8, 0, 0, 0};
    vt[9]  = '{1, 0, 4, 0, 0, 0};
    vt[10] = '{1, 0, 5, 1, 0, 0};
    vt[11] = '{1, 1, 8, 0, 0, 0};
    vt[12] = '{1, 1, 8, 1, 0, 0};
    vt[13] = '{0, 1, 8, 1, 1, 0};
    vt[14] = '{1, 1, 8, 0, 0, 0};
    vt[15] = '{0, 1, 8, 0, 0, 0};
`ifdef STOPWATCH_SEXAGESIMAL_EN
    max_bcd = 16'h9599; mid_lo = 16'h0599; mid_hi = 16'h1000; mid_lo_n = 599;
`else
    max_bcd = 16'h9999; mid_lo = 16'h0999; mid_hi = 16'h1000; mid_lo_n = 999;
`endif
    nv = 1;
    for (int i = 0; i < NDIG; i++) nv *= radix(i);
    edge_n = 0;
    model_reset();
    chk_en = 1;

    repeat (3) cyc();
    chk("rst_digits", Digits, 0);
    chk("rst_running", WatchRunning, 0);
    chk("rst_ovf", Overflow, 0);
    nSysReset = 1'b1;
    repeat (2) cyc();

    // Start latency: state flips exactly on edge DEB+3 after the first sampling edge.
    Buttons[1] = 1'b1;
    schedule(1, 0);
    repeat (DEB + 3) cyc();
    chk("lat_before", WatchRunning, 0);
    cyc();
    chk("lat_at", WatchRunning, 1);
    repeat (10 - (DEB + 4)) cyc();
    Buttons = '0;
    repeat (100) cyc();

    foreach (vt[i]) begin
      press(vt[i].b1, vt[i].b2, vt[i].hold, 20);
      chk($sformatf("vec%0d_run", i), WatchRunning, vt[i].run);
      chk($sformatf("vec%0d_lap", i), Lapped, vt[i].lap);
      chk($sformatf("vec%0d_ovf", i), Overflow, vt[i].ovf);
    end

    for (int i = 0; i < 80; i++) begin
      int sel, hold;
      sel  = $urandom_range(1, 3);
      hold = ($urandom_range(0, 9) < 2) ? $urandom_range(1, DEB) : $urandom_range(DEB + 1, 15);
      press(sel[0], sel[1], hold, $urandom_range(2 * DEB + 4, 60));
    end

    for (int i = 0; i < 4 && m != M_ZERO; i++) begin
      if (m == M_STOP) press(0, 1, 8, 20);
      else             press(1, 0, 8, 20);
    end
    chk("back_to_zero", WatchRunning, 0);

    // Long run through the wrap; only the landmark values are compared.
    press(1, 0, 8, 0);
    chk_en = 0;
    for (int i = 0; i < 40000 && exp_disp != mid_lo_n; i++) cyc();
    chk("mid_lo", Digits, mid_lo);
    for (int i = 0; i < 100 && exp_disp == mid_lo_n; i++) cyc();
    chk("mid_hi", Digits, mid_hi);
    for (int i = 0; i < 40000 && exp_disp != nv - 1; i++) cyc();
    chk("max_val", Digits, max_bcd);
    chk("max_ovf", Overflow, 0);
    for (int i = 0; i < 100 && exp_disp != 0; i++) cyc();
    chk("wrap_val", Digits, 0);
    chk("wrap_ovf", Overflow, 1);
    chk_en = 1;
    repeat (30) cyc();

    press(1, 0, 8, 20);
    Buttons[2] = 1'b1;
    schedule(0, 1);
    repeat (DEB + 4) cyc();
    chk("wreset_pulse", WatchReset, 1);
    cyc();
    chk("wreset_end", WatchReset, 0);
    Buttons = '0;
    repeat (20) cyc();
    chk("clr_digits", Digits, 0);
    chk("clr_ovf", Overflow, 0);

    // Asynchronous reset while in LAP, with start held through the release.
    press(1, 0, 8, 40);
    press(0, 1, 8, 30);
    chk("lap_before_rst", Lapped, 1);
    nSysReset  = 1'b0;
    Buttons[1] = 1'b1;
    #1;
    chk("arst_digits", Digits, 0);
    chk("arst_running", WatchRunning, 0);
    chk("arst_lapped", Lapped, 0);
    chk("arst_wreset", WatchReset, 0);
    chk("arst_ovf", Overflow, 0);
    model_reset();
    repeat (3) cyc();
    nSysReset = 1'b1;
    schedule(1, 0);
    repeat (10) cyc();
    Buttons = '0;
    repeat (20) cyc();
    chk("held_thru_reset", WatchRunning, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
